alu_arbiter: RTL

Two-requester arbiter and sequencer for the shared 3-bit ALU datapath. Each requester raises an asynchronous four-phase request carrying its operands and opcode. The block synchronizes both request lines with two-flop synchronizers, grants the ALU round-robin, issues a start pulse, and waits the fixed ALU latency. It then returns the registered result with an acknowledge that is held until the requester drops its request.

---
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter and sequencer for the shared ALU.
// Both four-phase requests are synchronized, one owner at a time is granted the ALU,
// and the result is returned with an acknowledge held until the owner drops its request.
// Optional build macro: ALU_ARB_FIXED_PRI_EN selects fixed priority (requester 0 wins ties).
module alu_arbiter #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH:0]   res,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_start,
    input  logic [WIDTH:0]   alu_result
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [1:0]         sync0, sync1;
    logic               req_s0, req_s1;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               owner, owner_d;
    logic               win;
    logic               ack0_d, ack1_d, busy_d, start_d;
    logic [WIDTH:0]     res_d;
    logic [1:0]         gnt_d;
    logic [WIDTH-1:0]   alu_a_d, alu_b_d;
    logic [1:0]         alu_op_d;
`ifdef ALU_ARB_FIXED_PRI_EN
`else
    logic               last, last_d;
`endif

    // Two-flop synchronizers for the asynchronous request lines
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0 <= 2'b00;
            sync1 <= 2'b00;
        end else begin
            sync0 <= {sync0[0], req0};
            sync1 <= {sync1[0], req1};
        end
    end

    assign req_s0 = sync0[1];
    assign req_s1 = sync1[1];

    // Winner among pending requests
    always_comb begin
`ifdef ALU_ARB_FIXED_PRI_EN
        win = !req_s0;
`else
        win = (req_s0 && req_s1) ? !last : req_s1;
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            res       <= '0;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 2'b00;
            alu_start <= 1'b0;
`ifdef ALU_ARB_FIXED_PRI_EN
`else
            last      <= 1'b1;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            owner     <= owner_d;
            ack0      <= ack0_d;
            ack1      <= ack1_d;
            res       <= res_d;
            gnt       <= gnt_d;
            busy      <= busy_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_op    <= alu_op_d;
            alu_start <= start_d;
`ifdef ALU_ARB_FIXED_PRI_EN
`else
            last      <= last_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        owner_d  = owner;
        ack0_d   = ack0;
        ack1_d   = ack1;
        res_d    = res;
        gnt_d    = gnt;
        alu_a_d  = alu_a;
        alu_b_d  = alu_b;
        alu_op_d = alu_op;
        start_d  = 1'b0;
`ifdef ALU_ARB_FIXED_PRI_EN
`else
        last_d   = last;
`endif
        case (state)
            IDLE: begin
                if (req_s0 || req_s1) begin
                    state_d  = EXEC;
                    owner_d  = win;
                    gnt_d    = win ? 2'b10 : 2'b01;
                    alu_a_d  = win ? a1 : a0;
                    alu_b_d  = win ? b1 : b0;
                    alu_op_d = win ? op1 : op0;
                    start_d  = 1'b1;
                    cnt_d    = CNT_W'(ALU_LAT);
                end
            end
            EXEC: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    res_d   = alu_result;
                    state_d = ACK;
                    if (owner) ack1_d = 1'b1;
                    else       ack0_d = 1'b1;
                end
            end
            ACK: begin
                if (!(owner ? req_s1 : req_s0)) begin
                    ack0_d  = 1'b0;
                    ack1_d  = 1'b0;
                    gnt_d   = 2'b00;
                    state_d = IDLE;
`ifdef ALU_ARB_FIXED_PRI_EN
`else
                    last_d  = owner;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule
